// File: rtl/uart_frame_pkg.sv
// Shared constants, state encoding and checksum helper for the UART command-frame parser.
package uart_frame_pkg;

    localparam logic [7:0]  HDR1      = 8'h55;
    localparam logic [7:0]  HDR2      = 8'hAA;
    localparam int unsigned FRAME_LEN = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR2 = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATH = 3'd3,
        ST_DATL = 3'd4,
        ST_CHK  = 3'd5
    } state_t;

    // 8-bit wrap-around sum of the three payload bytes
    function automatic logic [7:0] frame_sum(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic [7:0] c);
        logic [7:0] s;
        s = a + b;
        s = s + c;
        return s;
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter; expired flags the edge on which the count reaches TIMEOUT_CYC.
module uart_frame_timer #(
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != CW'(TIMEOUT_CYC))) begin
            r_count <= r_count + CW'(1);
        end
    end

    // clr has priority, so a byte landing on the expiry edge suppresses it
    assign expired = en && !clr && (r_count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_frame_parser.sv
// Decodes 55 AA ADDR DH DL CHK command frames from a byte receiver into register writes.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        cmd_valid,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        chk_err,
    output logic        tmo_err,
    output logic        busy
);

    state_t      r_state;
    logic [7:0]  r_addr;
    logic [7:0]  r_dath;
    logic [7:0]  r_datl;
    logic        r_cmd_valid;
    logic [7:0]  r_cmd_addr;
    logic [15:0] r_cmd_data;
    logic        r_chk_err;
    logic        r_tmo_err;
    logic        r_busy;

    logic w_clr;
    logic w_en;
    logic w_expired;

    assign w_clr = rx_done || (r_state == ST_IDLE);
    assign w_en  = (r_state != ST_IDLE);

    uart_frame_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .en     (w_en),
        .expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= 8'h00;
            r_dath      <= 8'h00;
            r_datl      <= 8'h00;
            r_cmd_valid <= 1'b0;
            r_cmd_addr  <= 8'h00;
            r_cmd_data  <= 16'h0000;
            r_chk_err   <= 1'b0;
            r_tmo_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_chk_err   <= 1'b0;
            r_tmo_err   <= 1'b0;
            if (rx_done) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (rx_data == HDR1) begin
                            r_state <= ST_HDR2;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_HDR2: begin
                        // a repeated 0x55 is treated as a fresh first header byte
                        if (rx_data == HDR2) begin
                            r_state <= ST_ADDR;
                        end else if (rx_data != HDR1) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    ST_ADDR: begin
                        r_addr  <= rx_data;
                        r_state <= ST_DATH;
                    end
                    ST_DATH: begin
                        r_dath  <= rx_data;
                        r_state <= ST_DATL;
                    end
                    ST_DATL: begin
                        r_datl  <= rx_data;
                        r_state <= ST_CHK;
                    end
                    ST_CHK: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        if (rx_data == frame_sum(r_addr, r_dath, r_datl)) begin
                            r_cmd_addr  <= r_addr;
                            r_cmd_data  <= {r_dath, r_datl};
                            r_cmd_valid <= 1'b1;
                        end else begin
                            r_chk_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if (w_expired) begin
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
                r_tmo_err <= 1'b1;
                r_addr    <= 8'h00;
                r_dath    <= 8'h00;
                r_datl    <= 8'h00;
            end
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_addr  = r_cmd_addr;
    assign cmd_data  = r_cmd_data;
    assign chk_err   = r_chk_err;
    assign tmo_err   = r_tmo_err;
    assign busy      = r_busy;

endmodule
